// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, pattern width,
// default timing values and the leading-one encoder used to find the first emitted bit.
package morse_pkg;

  localparam int PAT_W = 24;
  localparam int IDX_W = $clog2(PAT_W);

  localparam logic [7:0] SPACE_CODE         = 8'h20;
  localparam int         DEF_UNIT_DIV       = 6000000;
  localparam int         DEF_CHAR_GAP_UNITS = 2;
  localparam int         DEF_WORD_GAP_UNITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_SEND,
    ST_GAP
  } state_e;

  // Index of the most significant set bit; 0 for an all-zero pattern.
  function automatic logic [IDX_W-1:0] lead_one(input logic [PAT_W-1:0] pat);
    lead_one = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (pat[i]) lead_one = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit prescaler: counts 0..UNIT_DIV-1 and pulses tick on the last count.
// A restart forces the count back to 0 so every unit starts with a full period.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_DIV = DEF_UNIT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = $clog2(UNIT_DIV);
  localparam logic [CW-1:0]  LAST = CW'(UNIT_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || restart || tick) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Sequences one ASCII character through the external pattern lookup and keys the
// returned on/off pattern MSB-first, followed by the character or word gap.
// Optional sidetone output is built when MORSE_SIDETONE_EN is defined.
module morse_keyer_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_DIV       = DEF_UNIT_DIV,
  parameter int LOOKUP_LAT     = 2,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEF_WORD_GAP_UNITS
`ifdef MORSE_SIDETONE_EN
  ,
  parameter int TONE_DIV       = 62500
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic [7:0]       lut_code,
  input  logic [PAT_W-1:0] lut_pat,
  output logic             key_out,
  output logic             busy
`ifdef MORSE_SIDETONE_EN
  ,
  output logic             tone_out
`endif
);

  localparam int GAP_MAX = WORD_GAP_UNITS + CHAR_GAP_UNITS;
  localparam int GW      = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam int LW      = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);

  state_e           r_state, w_state_n;
  logic [7:0]       r_code, w_code_n;
  logic [PAT_W-1:0] r_pat, w_pat_n;
  logic [IDX_W-1:0] r_idx, w_idx_n, w_idx_dec;
  logic [GW-1:0]    r_gap, w_gap_n;
  logic [LW-1:0]    r_lat, w_lat_n;
  logic             r_key, w_key_n;
  logic             w_tick, w_restart;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = ~in_ready;
  assign lut_code  = r_code;
  assign key_out   = r_key;
  assign w_idx_dec = r_idx - 1'b1;

  // Hold the timer at 0 outside SEND/GAP and on every state change so each unit is full length.
  assign w_restart = (r_state != ST_SEND && r_state != ST_GAP) || (w_state_n != r_state);

  morse_unit_timer #(.UNIT_DIV(UNIT_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_pat   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_lat   <= '0;
      r_key   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_pat   <= w_pat_n;
      r_idx   <= w_idx_n;
      r_gap   <= w_gap_n;
      r_lat   <= w_lat_n;
      r_key   <= w_key_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_code_n  = r_code;
    w_pat_n   = r_pat;
    w_idx_n   = r_idx;
    w_gap_n   = r_gap;
    w_lat_n   = r_lat;
    w_key_n   = r_key;
    unique case (r_state)
      ST_IDLE: begin
        w_key_n = 1'b0;
        if (in_valid) begin
          w_code_n  = in_char;
          w_lat_n   = '0;
          w_state_n = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (r_lat == LW'(LOOKUP_LAT)) begin
          w_pat_n = lut_pat;
          if (lut_pat != '0) begin
            // The leading bit is always a 1, so the key rises together with the entry to SEND.
            w_idx_n   = lead_one(lut_pat);
            w_key_n   = 1'b1;
            w_state_n = ST_SEND;
          end else begin
            w_gap_n   = GW'(GAP_MAX);
            w_state_n = (GAP_MAX == 0) ? ST_IDLE : ST_GAP;
          end
        end else begin
          w_lat_n = r_lat + 1'b1;
        end
      end
      ST_SEND: begin
        if (w_tick) begin
          if (r_idx == '0) begin
            w_key_n   = 1'b0;
            w_gap_n   = GW'(CHAR_GAP_UNITS);
            w_state_n = (CHAR_GAP_UNITS == 0) ? ST_IDLE : ST_GAP;
          end else begin
            w_idx_n = w_idx_dec;
            w_key_n = r_pat[w_idx_dec];
          end
        end
      end
      ST_GAP: begin
        w_key_n = 1'b0;
        if (r_gap == '0) begin
          w_state_n = ST_IDLE;
        end else if (w_tick) begin
          w_gap_n = r_gap - 1'b1;
          if (r_gap == GW'(1)) w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TW = (TONE_DIV < 2) ? 1 : $clog2(TONE_DIV);

  logic [TW-1:0] r_tone_cnt;
  logic          r_tone;

  // Tone phase restarts high on each key rise and is cleared in the same edge the key drops.
  always_ff @(posedge clk) begin
    if (rst || !w_key_n) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (!r_key) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b1;
    end else if (r_tone_cnt == TW'(TONE_DIV - 1)) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

  assign tone_out = r_tone;
`endif

endmodule
